pool2x2_window_ctrl: RTL

- Sequencer for the 2x2 pooling line buffer: it drives the buffer's shift enable and input data, tracks row and column of every accepted pixel, and picks out the stride-2 window positions.
- Computes the 2x2 max from the four buffer taps and emits one pooled pixel per window.
- Sits between a conv-layer output stream and the next layer; one instance per pooling feature map.

---
 rtl/pool2x2_window_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/pool2x2_window_ctrl.sv
// pool2x2_window_ctrl: sequences a 2x2 pooling line buffer and emits the max of each stride-2 window.
module pool2x2_window_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              buf_en,
    output logic [DATA_W-1:0] buf_data,
    input  logic [DATA_W-1:0] tap_tl,
    input  logic [DATA_W-1:0] tap_tr,
    input  logic [DATA_W-1:0] tap_bl,
    input  logic [DATA_W-1:0] tap_br,
    output logic              pool_valid,
    output logic [DATA_W-1:0] pool_data,
    output logic              frame_done,
    output logic              busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              win_pend;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic [DATA_W-1:0] max_t;
    logic [DATA_W-1:0] max_b;
    logic [DATA_W-1:0] max_all;

    assign in_ready = state == RUN;
    assign accept   = in_valid & in_ready & ~abort;
    assign buf_en   = accept;
    assign buf_data = in_data;
    assign busy     = state != IDLE;
    assign last_col = col == CW'(IMG_W - 1);
    assign last_row = row == RW'(IMG_H - 1);

    always_comb begin
        max_t   = tap_tl > tap_tr ? tap_tl : tap_tr;
        max_b   = tap_bl > tap_br ? tap_bl : tap_br;
        max_all = max_t > max_b ? max_t : max_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_pend   <= 1'b0;
            pool_valid <= 1'b0;
            pool_data  <= '0;
            frame_done <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_pend   <= 1'b0;
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // a window closes on the bottom-right pixel of each 2x2 block
            win_pend   <= accept & row[0] & col[0];
            pool_valid <= win_pend;
            frame_done <= win_pend & (state == DRAIN);
            if (win_pend)
                pool_data <= max_all;
            if (accept) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col)
                    row <= last_row ? '0 : row + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    row   <= '0;
                    col   <= '0;
                    state <= RUN;
                end
                RUN:     if (accept && last_row && last_col) state <= DRAIN;
                DRAIN:   if (pool_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
